// File: rtl/nv_nvdla_hls_pkg.sv
// Shared helpers for the HLS converter pipes: signed range limits and stage handshake type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nv_nvdla_hls_pkg;

  // Valid/ready pair of one pipe stage
  typedef struct packed {
    logic vld;
    logic rdy;
  } pipe_hs_t;

  // Largest value representable in a w-bit two's complement number
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement number
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/nv_nvdla_hls_sat_trunc.sv
// Signed clip of a W_IN-bit value into W_OUT bits, flagging when the value was clipped.
// Latency: combinational.
// Backpressure: none; pure function of din.
module nv_nvdla_hls_sat_trunc
  import nv_nvdla_hls_pkg::*;
#(
  parameter int W_IN  = 33,
  parameter int W_OUT = 16
) (
  input  logic signed [W_IN-1:0]  din,
  output logic        [W_OUT-1:0] dout,
  output logic                    sat
);

  localparam logic signed [W_IN-1:0]  MAX_IN  = W_IN'(sat_max(W_OUT));
  localparam logic signed [W_IN-1:0]  MIN_IN  = W_IN'(sat_min(W_OUT));
  localparam logic signed [W_OUT-1:0] MAX_OUT = W_OUT'(sat_max(W_OUT));
  localparam logic signed [W_OUT-1:0] MIN_OUT = W_OUT'(sat_min(W_OUT));

  // Clip to the output range; exact boundary values pass through unflagged
  always_comb begin
    dout = din[W_OUT-1:0];
    sat  = 1'b0;
    if (din > MAX_IN) begin
      dout = MAX_OUT;
      sat  = 1'b1;
    end else if (din < MIN_IN) begin
      dout = MIN_OUT;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/nv_nvdla_hls_bias_sat_pipe.sv
// Adds a signed bias to the shifter result and saturates it to OUT_WIDTH; NVDLA_HLS_SAT_CNT_EN adds a clip counter.
// Latency: 2 cycles accept-to-out_pvld, 1 result per cycle.
// Backpressure: out_prdy ripples combinationally to in_prdy; a full pipe holds both stages and stalls input.
module nv_nvdla_hls_bias_sat_pipe
  import nv_nvdla_hls_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int BIAS_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  in_pvld,
  output logic                  in_prdy,
  input  logic [IN_WIDTH-1:0]   in_pd,
  input  logic [BIAS_WIDTH-1:0] cfg_bias,
  input  logic                  cfg_sat_clr,
  output logic                  out_pvld,
  input  logic                  out_prdy,
  output logic [OUT_WIDTH-1:0]  out_pd,
  output logic                  out_sat,
  output logic [CNT_WIDTH-1:0]  sat_cnt
);

  logic                       s1_vld;
  logic signed [IN_WIDTH:0]   s1_sum;
  logic                       s2_vld;
  logic        [OUT_WIDTH-1:0] s2_pd;
  logic                       s2_sat;
  pipe_hs_t                   s1_hs;
  pipe_hs_t                   s2_hs;
  logic signed [IN_WIDTH:0]   sum_nxt;
  logic        [OUT_WIDTH-1:0] clip_pd;
  logic                       clip_sat;

  // One extra bit of headroom means the bias add can never wrap
  assign sum_nxt = $signed({in_pd[IN_WIDTH-1], in_pd})
                 + $signed({{(IN_WIDTH + 1 - BIAS_WIDTH){cfg_bias[BIAS_WIDTH-1]}}, cfg_bias});

  // Ready chain: a stage can take new data if empty or draining this cycle
  assign s2_hs.vld = s2_vld;
  assign s2_hs.rdy = !s2_vld || out_prdy;
  assign s1_hs.vld = s1_vld;
  assign s1_hs.rdy = !s1_vld || s2_hs.rdy;
  assign in_prdy   = s1_hs.rdy;

  nv_nvdla_hls_sat_trunc #(
    .W_IN  (IN_WIDTH + 1),
    .W_OUT (OUT_WIDTH)
  ) u_sat (
    .din  (s1_sum),
    .dout (clip_pd),
    .sat  (clip_sat)
  );

  // Stage 1: capture biased sum on input accept, hold while stage 2 is blocked
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      s1_vld <= 1'b0;
      s1_sum <= '0;
    end else begin
      s1_vld <= (in_pvld && s1_hs.rdy) || (s1_hs.vld && !s2_hs.rdy);
      if (in_pvld && s1_hs.rdy) begin
        s1_sum <= sum_nxt;
      end
    end
  end

  // Stage 2: register the saturated result, hold while the sink stalls
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      s2_vld <= 1'b0;
      s2_pd  <= '0;
      s2_sat <= 1'b0;
    end else begin
      s2_vld <= (s1_hs.vld && s2_hs.rdy) || (s2_hs.vld && !out_prdy);
      if (s1_hs.vld && s2_hs.rdy) begin
        s2_pd  <= clip_pd;
        s2_sat <= clip_sat;
      end
    end
  end

  assign out_pvld = s2_hs.vld;
  assign out_pd   = s2_pd;
  assign out_sat  = s2_sat;

`ifdef NVDLA_HLS_SAT_CNT_EN
  logic                 out_fire;
  logic [CNT_WIDTH-1:0] sat_q;

  assign out_fire = out_pvld && out_prdy;

  // Count clipped outputs as they leave; clear wins, count sticks at all-ones
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      sat_q <= '0;
    end else if (cfg_sat_clr) begin
      sat_q <= '0;
    end else if (out_fire && s2_sat && !(&sat_q)) begin
      sat_q <= sat_q + CNT_WIDTH'(1);
    end
  end

  assign sat_cnt = sat_q;
`else
  logic sat_clr_unused;

  assign sat_clr_unused = cfg_sat_clr;
  assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_hls_bias_sat_pipe.sv
module tb_nv_nvdla_hls_bias_sat_pipe;

`ifdef NVDLA_HLS_SAT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_pvld = 1'b0;
  logic        in_prdy;
  logic [31:0] in_pd = '0;
  logic [15:0] cfg_bias = '0;
  logic        cfg_sat_clr = 1'b0;
  logic        out_pvld;
  logic        out_prdy = 1'b1;
  logic [15:0] out_pd;
  logic        out_sat;
  logic [3:0]  sat_cnt;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  logic [16:0] exp_q[$];

  typedef struct {
    logic [31:0] d;
    logic [15:0] b;
    logic [15:0] p;
    logic        s;
  } vec_t;

  // Hand-computed: in_pd, bias, expected out_pd, expected out_sat
  vec_t vecs[11] = '{
    '{32'h00007FF0, 16'h0020, 16'h7FFF, 1'b1},
    '{32'h00007FFF, 16'h0000, 16'h7FFF, 1'b0},
    '{32'h80000000, 16'h8000, 16'h8000, 1'b1},
    '{32'hFFFF8000, 16'h0000, 16'h8000, 1'b0},
    '{32'h7FFFFFFF, 16'h7FFF, 16'h7FFF, 1'b1},
    '{32'hFFFFFFF0, 16'h0005, 16'hFFF5, 1'b0},
    '{32'h00008000, 16'hFFFF, 16'h7FFF, 1'b0},
    '{32'hFFFF7FFF, 16'h0001, 16'h8000, 1'b0},
    '{32'h00010000, 16'h0000, 16'h7FFF, 1'b1},
    '{32'hFFFF7FFF, 16'h0000, 16'h8000, 1'b1},
    '{32'h12345678, 16'h8000, 16'h7FFF, 1'b1}
  };

  nv_nvdla_hls_bias_sat_pipe #(
    .IN_WIDTH   (32),
    .BIAS_WIDTH (16),
    .OUT_WIDTH  (16),
    .CNT_WIDTH  (4)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy),
    .in_pd          (in_pd),
    .cfg_bias       (cfg_bias),
    .cfg_sat_clr    (cfg_sat_clr),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_pd         (out_pd),
    .out_sat        (out_sat),
    .sat_cnt        (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_pvld && out_prdy) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {15'd0, out_sat, out_pd}, 32'hFFFFFFFF);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("out_pd", 32'(out_pd), 32'(e[15:0]));
        chk("out_sat", 32'(out_sat), 32'(e[16]));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [15:0] b, input logic [15:0] p, input logic s);
    bit ok;
    ok = 1'b0;
    in_pvld  = 1'b1;
    in_pd    = d;
    cfg_bias = b;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_prdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back({s, p});
    end
    @(posedge clk);
    #1;
    in_pvld = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rx_base;
    bit saw_stall;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_pvld", 32'(out_pvld), 32'd0);
    chk("rst_out_pd", 32'(out_pd), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_prdy", 32'(in_prdy), 32'd1);

    // Basic vector with latency check: valid appears 2 cycles after accept
    in_pvld  = 1'b1;
    in_pd    = 32'h00000010;
    cfg_bias = 16'h0005;
    @(negedge clk);
    chk("lat_accept", 32'(in_prdy), 32'd1);
    exp_q.push_back({1'b0, 16'h0015});
    @(posedge clk);
    #1;
    in_pvld = 1'b0;
    chk("lat_c1_pvld", 32'(out_pvld), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_c2_pvld", 32'(out_pvld), 32'd1);
    drain();

    // Directed clip/boundary table, back to back
    foreach (vecs[i]) send(vecs[i].d, vecs[i].b, vecs[i].p, vecs[i].s);
    drain();
    chk("cnt_after_table", 32'(sat_cnt), CNT_ON ? 32'd6 : 32'd0);

    // Backpressure: 8 values, sink stalls in cycles 3-7
    rx_base   = rx_cnt;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i * 3), 16'h0001, 16'(i * 3 + 1), 1'b0);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_prdy = !(c >= 3 && c <= 7);
          @(negedge clk);
          if (in_pvld && !in_prdy && out_pvld) saw_stall = 1'b1;
          @(posedge clk);
          #1;
        end
        out_prdy = 1'b1;
      end
    join
    drain();
    chk("bp_stall_seen", 32'(saw_stall), 32'd1);
    chk("bp_rx_count", 32'(rx_cnt - rx_base), 32'd8);

    // Counter clear coincident with a clipped output transfer
    out_prdy = 1'b0;
    send(32'h00010000, 16'h0000, 16'h7FFF, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_pvld) break;
    end
    chk("clr_held_pvld", 32'(out_pvld), 32'd1);
    @(posedge clk);
    #1;
    cfg_sat_clr = 1'b1;
    out_prdy    = 1'b1;
    @(posedge clk);
    #1;
    cfg_sat_clr = 1'b0;
    chk("cnt_clr_wins", 32'(sat_cnt), 32'd0);
    drain();

    // 16 clips into a 4-bit counter: sticks at all-ones
    for (int i = 0; i < 16; i++) send(32'h80000000, 16'h8000, 16'h8000, 1'b1);
    drain();
    chk("cnt_stick", 32'(sat_cnt), CNT_ON ? 32'd15 : 32'd0);

    // Reset with two values in flight
    out_prdy = 1'b0;
    send(32'h00000100, 16'h0000, 16'h0100, 1'b0);
    send(32'h00000200, 16'h0000, 16'h0200, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_out_pvld", 32'(out_pvld), 32'd0);
    chk("mrst_out_pd", 32'(out_pd), 32'd0);
    chk("mrst_sat_cnt", 32'(sat_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_prdy = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_no_stale", 32'(out_pvld), 32'd0);
    rx_base = rx_cnt;
    send(32'h00000010, 16'h0005, 16'h0015, 1'b0);
    drain();
    chk("mrst_rx_count", 32'(rx_cnt - rx_base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
